// File: rtl/window_denormalizer.sv
// Rescales a window-multiplier product to full magnitude by shifting it one bit
// per cycle by addrA + addrB - 2*(WINDOW-1) positions. Positive shifts go left.
module window_denormalizer #(
    parameter int WINDOW      = 8,
    parameter int PSIZE       = 2 * WINDOW,
    parameter int ADDRESSSIZE = 4,
    parameter int OUTSIZE     = 2 * (2 ** ADDRESSSIZE)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [PSIZE-1:0]       product,
    input  logic [ADDRESSSIZE-1:0] addrA,
    input  logic [ADDRESSSIZE-1:0] addrB,
    output logic                   busy,
    output logic                   done,
    output logic [OUTSIZE-1:0]     result
);

    // state   | meaning
    // S_IDLE  | waiting for start
    // S_SHIFT | moving acc one bit per cycle until count reaches zero
    // S_DONE  | one-cycle done pulse, result valid
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    localparam int SW = ADDRESSSIZE + 2;
    localparam logic signed [SW-1:0] BIAS = SW'(2 * (WINDOW - 1));

    state_t               state_q, state_d;
    logic [OUTSIZE-1:0]   acc_q, acc_d;
    logic [OUTSIZE-1:0]   result_q, result_d;
    logic [SW-1:0]        count_q, count_d;
    logic                 dir_q, dir_d;

    logic signed [SW-1:0] shift_s;
    logic [SW-1:0]        shift_abs;
    logic [OUTSIZE-1:0]   product_ext;

    assign shift_s     = $signed({2'b00, addrA}) + $signed({2'b00, addrB}) - BIAS;
    assign shift_abs   = shift_s[SW-1] ? (-shift_s) : shift_s;
    assign product_ext = {{(OUTSIZE - PSIZE){1'b0}}, product};

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        result_d = result_q;
        count_d  = count_q;
        dir_d    = dir_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    acc_d   = product_ext;
                    count_d = shift_abs;
                    dir_d   = shift_s[SW-1];
                    if (shift_abs == '0) begin
                        result_d = product_ext;
                        state_d  = S_DONE;
                    end else begin
                        state_d = S_SHIFT;
                    end
                end
            end
            S_SHIFT: begin
                // dir_q high means right shift; dropped LSBs are truncation
                acc_d   = dir_q ? (acc_q >> 1) : (acc_q << 1);
                count_d = count_q - SW'(1);
                if (count_q == SW'(1)) begin
                    result_d = acc_d;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            result_q <= '0;
            count_q  <= '0;
            dir_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            count_q  <= count_d;
            dir_q    <= dir_d;
        end
    end

    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE);
    assign result = result_q;

endmodule
